// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// rstatus codes, the redirect register and the arbiter FSM encoding.
package regfile_wb_arbiter_pkg;

  localparam logic [2:0] RSTATUS_ADD  = 3'd1;
  localparam logic [2:0] RSTATUS_ADDI = 3'd2;
  localparam logic [2:0] RSTATUS_SUB  = 3'd3;
  localparam logic [2:0] RSTATUS_MUL  = 3'd4;
  localparam logic [2:0] RSTATUS_DIV  = 3'd5;
  localparam logic [4:0] RSTATUS_REG  = 5'd30;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        exc;
  } wr_t;

  function automatic logic [2:0] wb_code(
    input logic       ovf,
    input logic [1:0] op
  );
    logic [2:0] c;
    c = 3'd0;
    if (ovf) begin
      unique case (op)
        2'd1:    c = RSTATUS_ADD;
        2'd2:    c = RSTATUS_ADDI;
        2'd3:    c = RSTATUS_SUB;
        default: c = 3'd0;
      endcase
    end
    return c;
  endfunction

  function automatic logic [2:0] md_code(
    input logic exc,
    input logic is_mult
  );
    logic [2:0] c;
    c = 3'd0;
    if (exc) c = is_mult ? RSTATUS_MUL : RSTATUS_DIV;
    return c;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rstatus_redirect.sv
// Combinational rstatus redirection of one register write.
// A non-zero code retargets the write to $r30 carrying the code.
module rstatus_redirect
  import regfile_wb_arbiter_pkg::*;
(
  input  logic        v,
  input  logic [4:0]  rg,
  input  logic [31:0] data,
  input  logic [2:0]  code,
  output logic        wr_we,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic        wr_exc
);

  always_comb begin
    wr_we   = 1'b0;
    wr_reg  = 5'd0;
    wr_data = 32'd0;
    wr_exc  = 1'b0;
    if (v) begin
      if (code != 3'd0) begin
        wr_reg  = RSTATUS_REG;
        wr_data = {29'd0, code};
        wr_exc  = 1'b1;
      end else begin
        wr_reg  = rg;
        wr_data = data;
      end
      // $r0 is hardwired; never assert the port for it
      wr_we = (wr_reg != 5'd0);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between the W stage and multdiv.
// A colliding multdiv result is held and drained, stalling W if starved.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_data,
  input  logic             wb_ovf,
  input  logic [1:0]       wb_op,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic             md_is_mult,
  input  logic [4:0]       md_reg,
  input  logic [31:0]      md_data,
  output logic             md_accept,
  output logic             stall_wb,
  output logic             ctrl_writeEnable,
  output logic [4:0]       ctrl_writeReg,
  output logic [31:0]      data_writeReg,
  output logic [CNT_W-1:0] exc_count,
  output logic             proto_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            stall_d;
  wr_t             hold_q, hold_d;
  wr_t             wb_wr, md_wr, out_wr;

  rstatus_redirect u_wb_redir (
    .v       (wb_valid),
    .rg      (wb_reg),
    .data    (wb_data),
    .code    (wb_code(wb_ovf, wb_op)),
    .wr_we   (wb_wr.we),
    .wr_reg  (wb_wr.rg),
    .wr_data (wb_wr.data),
    .wr_exc  (wb_wr.exc)
  );

  rstatus_redirect u_md_redir (
    .v       (md_ready),
    .rg      (md_reg),
    .data    (md_data),
    .code    (md_code(md_exception, md_is_mult)),
    .wr_we   (md_wr.we),
    .wr_reg  (md_wr.rg),
    .wr_data (md_wr.data),
    .wr_exc  (md_wr.exc)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    hold_d  = hold_q;
    out_wr  = '0;
    unique case (state_q)
      IDLE: begin
        if (md_ready && !wb_valid) begin
          out_wr = md_wr;
        end else if (md_ready) begin
          out_wr  = wb_wr;
          hold_d  = md_wr;
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          out_wr = wb_wr;
        end
      end
      HOLD: begin
        // during the stall cycle W repeats, so its write is dropped
        if (!wb_valid || stall_wb) begin
          out_wr  = hold_q;
          hold_d  = '0;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          out_wr  = wb_wr;
          cnt_d   = cnt_inc;
          stall_d = (cnt_inc == SW'(STARVE_MAX));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stall_wb  <= 1'b0;
      hold_q    <= '0;
      exc_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_wb <= stall_d;
      hold_q   <= hold_d;
      if (out_wr.we && out_wr.exc && (exc_count != '1))
        exc_count <= exc_count + 1'b1;
      if (md_ready && (state_q == HOLD))
        proto_err <= 1'b1;
    end
  end

  assign md_accept        = (state_q == IDLE);
  assign ctrl_writeEnable = out_wr.we;
  assign ctrl_writeReg    = out_wr.rg;
  assign data_writeReg    = out_wr.data;

endmodule
